// File: rtl/bicubic_nx_acc_unpack.sv
// Result unpacker for the N-lane DSP accumulator: in-flight tags, round/shift/saturate to 8-bit
// pixels, output FIFO as AXI-Stream master, credit-based clken. Option: BICUBIC_ACC_SAT_STAT_EN.
module bicubic_nx_acc_unpack #(
  parameter int unsigned PARALLEL_CORE = 4,
  parameter int unsigned ACC_LATENCY   = 4,
  parameter int unsigned FRAC_BITS     = 14,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         aresetn,
  output logic                         clken,
  input  logic                         issue_valid,
  input  logic                         issue_last,
  input  logic [PARALLEL_CORE*48-1:0]  result,
  output logic [PARALLEL_CORE*8-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [15:0]                  sat_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DataW = PARALLEL_CORE * 8;
  localparam logic signed [48:0] Half = 49'sd1 <<< (FRAC_BITS - 1);

  // Tag pipeline mirroring the accumulator's clken-gated pipeline
  logic [ACC_LATENCY-1:0] v_q, v_d, l_q, l_d;
  logic [4:0]             inflight;
  logic                   retire;

  // FIFO state
  logic [DataW:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   push, pop;
  logic [DataW:0]         head;

  // Lane conversion
  logic [DataW-1:0]         pix;
  logic [PARALLEL_CORE-1:0] clamp;

  function automatic logic [8:0] convert_lane(input logic [47:0] acc);
    logic signed [48:0] s;
    logic signed [48:0] q;
    logic [8:0]         res;
    s = $signed({acc[47], acc}) + Half;
    q = s >>> FRAC_BITS;
    if (q[48]) begin
      res = {1'b1, 8'd0};
    end else if (|q[47:8]) begin
      res = {1'b1, 8'd255};
    end else begin
      res = {1'b0, q[7:0]};
    end
    return res;
  endfunction

  always_comb begin
    pix   = '0;
    clamp = '0;
    for (int i = 0; i < PARALLEL_CORE; i++) begin
      logic [8:0] conv;
      conv             = convert_lane(result[i*48 +: 48]);
      pix[i*8 +: 8]    = conv[7:0];
      clamp[i]         = conv[8];
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < ACC_LATENCY; k++) begin
      inflight = inflight + 5'(v_q[k]);
    end
  end

  // Credit: anything already in flight has a FIFO slot reserved for it
  always_comb begin
    logic [31:0] used;
    used  = 32'(count_q) + 32'(inflight);
    clken = (used < FIFO_DEPTH);
  end

  assign retire = clken & v_q[ACC_LATENCY-1];

  always_comb begin
    v_d = v_q;
    l_d = l_q;
    if (clken) begin
      v_d[0] = issue_valid;
      l_d[0] = issue_valid & issue_last;
      for (int k = 1; k < ACC_LATENCY; k++) begin
        v_d[k] = v_q[k-1];
        l_d[k] = l_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= v_d;
      l_q <= l_d;
    end
  end

  assign push = retire;
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {l_q[ACC_LATENCY-1], pix};
    end
  end

  assign head          = mem_q[rptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DataW-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DataW];

`ifdef BICUBIC_ACC_SAT_STAT_EN
  logic [15:0] sat_q, sat_d;

  always_comb begin
    logic [16:0] sum;
    logic [7:0]  n;
    n = '0;
    for (int i = 0; i < PARALLEL_CORE; i++) begin
      n = n + 8'(clamp[i]);
    end
    sum   = {1'b0, sat_q} + 17'(n);
    sat_d = sat_q;
    if (retire) begin
      sat_d = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_count = sat_q;
`else
  logic unused_clamp;
  assign unused_clamp = ^clamp;
  assign sat_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_bicubic_nx_acc_unpack.sv
// Scenario bench for bicubic_nx_acc_unpack: an accumulator model feeds `result`, a scoreboard
// queue holds expected beats and a negedge monitor pops and compares them on each handshake.
module tb_bicubic_nx_acc_unpack;

  localparam int P = 4;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           aresetn;
  logic           clken;
  logic           issue_valid;
  logic           issue_last;
  logic [P*48-1:0] result;
  logic [P*8-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;
  logic [15:0]    sat_count;

  logic [P*48-1:0] issue_data;
  logic [P*48-1:0] acc_pipe [L];

  logic [P*8:0] sb_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int beats = 0;
  int last_beats = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  bicubic_nx_acc_unpack dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .clken         (clken),
    .issue_valid   (issue_valid),
    .issue_last    (issue_last),
    .result        (result),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .sat_count     (sat_count)
  );

  // Accumulator stand-in: same clken-gated latency as the real array
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < L; k++) acc_pipe[k] <= '0;
    end else if (clken) begin
      acc_pipe[0] <= issue_data;
      for (int k = 1; k < L; k++) acc_pipe[k] <= acc_pipe[k-1];
    end
  end
  assign result = acc_pipe[L-1];

  always @(negedge clk) begin
    if (aresetn && tvalid && tready) begin
      logic [P*8:0] exp_beat;
      beats++;
      if (tlast) last_beats++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got last=%b data=%h, required no beat", tlast, tdata);
      end else begin
        exp_beat = sb_q.pop_front();
        if ({tlast, tdata} !== exp_beat) begin
          n_fail++;
          $display("FAIL beat_data: got last=%b data=%h, required last=%b data=%h",
                   tlast, tdata, exp_beat[P*8], exp_beat[P*8-1:0]);
        end
      end
    end
  end

  task automatic issue_group(input logic [P*48-1:0] d, input logic [P*8-1:0] px,
                             input logic last, output bit acc);
    issue_valid = 1'b1;
    issue_data  = d;
    issue_last  = last;
    acc = clken;
    if (acc) sb_q.push_back({last, px});
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
  endtask

  // Random group whose lanes all round to a known in-range pixel
  task automatic make_group(output logic [P*48-1:0] d, output logic [P*8-1:0] px);
    for (int i = 0; i < P; i++) begin
      int k;
      int off;
      k   = int'($urandom_range(1, 254));
      off = int'($urandom_range(0, 16383)) - 8192;
      d[i*48 +: 48] = 48'(longint'(k) * 16384 + longint'(off));
      px[i*8 +: 8]  = 8'(k);
    end
  endtask

  task automatic issue_until_accepted(input logic [P*48-1:0] d, input logic [P*8-1:0] px,
                                      input logic last);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) issue_group(d, px, last, acc);
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL issue_timeout: got accepted=0, required accepted=1");
    end
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !tvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    issue_valid = 1'b0;
    issue_last = 1'b0;
    issue_data = '0;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, required 0", tvalid); end
    n_checks++;
    if (tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h, required 0", tdata); end
    n_checks++;
    if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, required 0", tlast); end
    n_checks++;
    if (clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b, required 1", clken); end
    n_checks++;
    if (sat_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_sat: got %0d, required 0", sat_count);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tvalid !== 1'b0 || clken !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: got tvalid=%b clken=%b, required 0/1", tvalid, clken);
    end
  endtask

  task automatic test_rounding;
    logic [47:0] lane0 [2];
    logic [7:0]  pxv [2];
    bit ok;
    lane0[0] = 48'd1646591;  // 100*2^14 + 8191
    lane0[1] = 48'd1646592;  // 100*2^14 + 8192
    pxv[0] = 8'd100;
    pxv[1] = 8'd101;
    tready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bit acc;
      n_checks++;
      if (clken !== 1'b1) begin n_fail++; $display("FAIL round_clken: got %b, required 1", clken); end
      issue_group({144'd0, lane0[r]}, {24'd0, pxv[r]}, 1'b0, acc);
      for (int c = 1; c <= L; c++) begin
        @(posedge clk); #1;
        n_checks++;
        if (tvalid !== (c == L)) begin
          n_fail++;
          $display("FAIL round_latency: edge %0d got tvalid=%b, required %b", c, tvalid, c == L);
        end
      end
      wait_empty(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL round_drain: got pending=%0d, required 0", sb_q.size()); end
    end
  endtask

  task automatic test_saturation;
    bit acc;
    bit ok;
    logic [P*48-1:0] d;
    d = {48'd4177920, 48'd4915200, 48'hFFFF_FFF0_0000, 48'hFFFF_FFFF_FFFF};
    tready = 1'b1;
    issue_group(d, {8'd255, 8'd255, 8'd0, 8'd0}, 1'b0, acc);
    wait_empty(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_drain: got pending=%0d, required 0", sb_q.size()); end
`ifdef BICUBIC_ACC_SAT_STAT_EN
    exp_sat = exp_sat + 2;
`endif
    n_checks++;
    if (sat_count !== 16'(exp_sat)) begin
      n_fail++; $display("FAIL sat_count: got %0d, required %0d", sat_count, exp_sat);
    end
  endtask

  task automatic test_backpressure;
    int accepted;
    int b0;
    bit ok;
    logic [P*48-1:0] d;
    logic [P*8-1:0] px;
    accepted = 0;
    b0 = beats;
    tready = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      n_checks++;
      if (clken !== (accepted < 8)) begin
        n_fail++;
        $display("FAIL bp_clken: cycle %0d got %b, required %b", cyc, clken, accepted < 8);
      end
      if (clken) begin
        bit acc;
        make_group(d, px);
        issue_group(d, px, 1'b0, acc);
        if (acc) accepted++;
      end else begin
        // Issue offered while stalled must be ignored
        issue_valid = 1'b1;
        issue_data  = {P{48'hFFFF_FFFF_FFFF}};
        @(posedge clk); #1;
        issue_valid = 1'b0;
      end
    end
    n_checks++;
    if (accepted != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 8", accepted); end
    tready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      make_group(d, px);
      issue_until_accepted(d, px, 1'b0);
    end
    wait_empty(ok);
    n_checks++;
    if (!ok || beats - b0 != 12) begin
      n_fail++; $display("FAIL bp_drain: got beats=%0d, required 12", beats - b0);
    end
  endtask

  task automatic test_tlast;
    int lb0;
    bit ok;
    lb0 = last_beats;
    fork
      begin
        logic [P*48-1:0] d;
        logic [P*8-1:0] px;
        for (int g = 0; g < 6; g++) begin
          make_group(d, px);
          issue_until_accepted(d, px, g == 5);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tready = 1'b1;
    wait_empty(ok);
    n_checks++;
    if (!ok || last_beats - lb0 != 1) begin
      n_fail++; $display("FAIL tlast_count: got %0d, required 1", last_beats - lb0);
    end
  endtask

  task automatic test_stall;
    int b0;
    bit ok;
    logic [P*48-1:0] d;
    logic [P*8-1:0] px;
    b0 = beats;
    tready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      make_group(d, px);
      issue_until_accepted(d, px, 1'b0);
    end
    repeat (6) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      make_group(d, px);
      issue_until_accepted(d, px, 1'b0);
    end
    // Oldest of the second batch sits at the last tag stage while held off
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (clken !== 1'b0 || tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got clken=%b tvalid=%b, required 0/1", clken, tvalid);
      end
      @(posedge clk); #1;
    end
    tready = 1'b1;
    wait_empty(ok);
    n_checks++;
    if (!ok || beats - b0 != 8) begin
      n_fail++; $display("FAIL stall_drain: got beats=%0d, required 8", beats - b0);
    end
  endtask

  task automatic test_reset_mid;
    int b0;
    bit ok;
    logic [P*48-1:0] d;
    logic [P*8-1:0] px;
    tready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      make_group(d, px);
      issue_until_accepted(d, px, 1'b0);
    end
    repeat (6) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      make_group(d, px);
      issue_until_accepted(d, px, 1'b0);
    end
    #2;
    aresetn = 1'b0;
    sb_q.delete();
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || clken !== 1'b1) begin
      n_fail++; $display("FAIL midreset: got tvalid=%b clken=%b, required 0/1", tvalid, clken);
    end
    n_checks++;
    if (sat_count !== 16'd0) begin
      n_fail++; $display("FAIL midreset_sat: got %0d, required 0", sat_count);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    b0 = beats;
    tready = 1'b1;
    make_group(d, px);
    issue_until_accepted(d, px, 1'b1);
    wait_empty(ok);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || beats - b0 != 1) begin
      n_fail++; $display("FAIL midreset_beats: got %0d, required 1", beats - b0);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_tlast();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bicubic_nx_acc_unpack.md
# bicubic_nx_acc_unpack

Result-side companion to the N-lane DSP 4-input accumulator in the Bicubic pipeline. It tracks which accumulator issues are in flight, and captures each lane's 48-bit signed sum when it emerges. Each sum is rounded, scaled down by the coefficient fraction width and saturated to an 8-bit pixel. The packed pixels are buffered in a small FIFO and presented as an AXI-Stream master. The block also generates the accumulator's clock enable as a credit-based backpressure signal, so no result is ever dropped.

## Interface
- PARALLEL_CORE, 4, number of accumulator lanes; must match the accumulator array.
- ACC_LATENCY, 4, number of clken-enabled edges from issue to a valid `result`; range 1..15.
- FRAC_BITS, 14, fractional bits of the accumulated sum; range 1..46.
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥ ACC_LATENCY+1.

Ports:
- clk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- clken  out  1  enable for the accumulator array and its upstream issue stage.
- issue_valid  in  1  a lane group is issued into the accumulator this cycle; honoured only when clken=1.
- issue_last  in  1  the issued group is the last of a line; qualified like issue_valid.
- result  in  PARALLEL_CORE*48  accumulator outputs; lane i at [i*48 +: 48], two's complement.
- m_axis_tdata  out  PARALLEL_CORE*8  pixels; lane i at [i*8 +: 8].
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  end of line.
- sat_count  out  16  saturated-lane counter; present only with the statistics option (see Configuration).

## Operation
- **Tag pipeline:** v[0..ACC_LATENCY-1] carries valid bits and l[0..ACC_LATENCY-1] carries last bits. It advances only on edges where clken=1: v[0]<=issue_valid, v[k]<=v[k-1], and l likewise.
- **Retire:** when v[ACC_LATENCY-1]=1 and clken=1, `result` is captured in that cycle, converted and written to the FIFO together with l[ACC_LATENCY-1].
  - While clken=0 the tags hold and no capture occurs, so each result is captured exactly once.
- **Conversion per lane:** s = result + 2^(FRAC_BITS-1), computed with a 49-bit sign-extended add. Then q = s >>> FRAC_BITS (arithmetic shift). The pixel is 0 if q<0, 255 if q>255, otherwise q[7:0].
- **Credit:** inflight = popcount(v) and credit = FIFO_DEPTH − fifo_count − inflight. clken = (credit ≥ 1), combinational from registers.
  - FIFO_DEPTH ≥ ACC_LATENCY+1 guarantees that clken is 1 whenever the FIFO is empty, so the credit loop cannot deadlock.
- **issue_valid while clken=0:** the issue is ignored; upstream must hold the issue.
- **FIFO:**
  - Simultaneous write and pop at full is legal; the credit scheme means the FIFO never overflows.
  - Pop occurs when tvalid && tready.
  - tdata and tlast are stable while tvalid=1 and tready=0.
- **Reset (asynchronous, any time):** clears v, l, the FIFO pointers and counters. In-flight results are discarded. The upstream stage and the accumulator reset alongside.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - sat_count=0.
  - clken=1, because all counts are zero.
- Latency: with no stall, an issue at edge t appears as tvalid=1 in the cycle after edge t+ACC_LATENCY. That is ACC_LATENCY+1 cycles, including the FIFO's registered head.
- Throughput: one lane group per cycle while tready=1.
- clken reacts in the same cycle as a counter change; there is no extra pipeline delay.

## Configuration
- BICUBIC_ACC_SAT_STAT_EN:
  - When defined, sat_count increments at each retire by the number of lanes that clamped (q<0 or q>255). It stops at 0xFFFF and is cleared only by reset.
  - When undefined, sat_count is tied to 0, there is no counter logic, and all other behaviour is identical.

## Test plan
- **Rounding:** ACC_LATENCY=4 and FRAC_BITS=14. Single issues with lane 0 = 100·2^14+8191 → pixel 100; lane 0 = 100·2^14+8192 → pixel 101. Output appears 5 cycles after the issue.
- **Saturation:** lanes = {−1, −2^20, 300·2^14, 255·2^14} → pixels {0, 0, 255, 255}. With the macro defined, sat_count=2; without it, sat_count=0.
- **Backpressure:** hold tready=0 and issue every cycle that clken=1.
  - clken falls when fifo_count+inflight reaches 8.
  - After tready is released, exactly 8 groups drain in issue order, and issue resumes with no loss or duplication.
- **tlast:** issue 6 groups with issue_last on the 6th, using random tready → tlast=1 only on the 6th output beat.
- **Stall during flight:** drive clken low mid-flight via a full FIFO while v[3]=1 and tready=0 for 3 cycles → the result is captured once, after clken returns.
- **Mid-stream reset:** assert aresetn=0 with 3 in flight and 4 entries in the FIFO → tvalid=0 immediately and clken=1. After release, a new single issue produces exactly one beat.
